// File: rtl/sar_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sar_pkg : shared types and constants for the SAR ADC controller
// Rev 1.0
// ----------------------------------------------------------------------------
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_t;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 2;

    localparam int AVG_COUNT = 4;
    localparam int AVG_SHIFT = 2;

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_cmp_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sar_cmp_sync : two-flop synchronizer for the asynchronous comparator output
// Rev 1.0
// ----------------------------------------------------------------------------
module sar_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sar_cmp_sync
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sar_adc_ctrl : successive-approximation controller driving the reference DAC
// Optional 4x averaging when SAR_AVG_EN is defined.           Rev 1.0
// ----------------------------------------------------------------------------
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int C_PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int C_CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WIDTH-1:0]   C_MSB     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [C_PTR_W-1:0] C_PTR_TOP = C_PTR_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_END = C_CNT_W'(SETTLE_CYCLES - 1);

    sar_state_t         r_state;
    sar_state_t         w_state_nxt;
    logic [C_PTR_W-1:0] r_ptr;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dac;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;

    logic               w_cmp_s;
    logic               w_start;
    logic               w_abort;
    logic               w_settled;
    logic               w_last;
    logic               w_final;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_dac_dec;

    sar_cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (w_cmp_s)
    );

    assign w_start   = start && !abort;
    assign w_abort   = abort && ((r_state == ST_SETTLE) || (r_state == ST_DECIDE));
    assign w_settled = (r_cnt == C_CNT_END);
    assign w_last    = (r_ptr == '0);

`ifdef SAR_AVG_EN
    localparam int C_CONV_W = $clog2(AVG_COUNT);

    logic [WIDTH+1:0]    r_acc;
    logic [C_CONV_W-1:0] r_conv;
    logic [WIDTH+1:0]    w_sum;

    assign w_sum   = r_acc + {2'b00, r_dac};
    assign w_final = (r_conv == C_CONV_W'(AVG_COUNT - 1));
    assign w_res   = WIDTH'(w_sum >> AVG_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_conv <= '0;
        end else if (w_abort || ((r_state == ST_DONE) && w_final)) begin
            r_acc  <= '0;
            r_conv <= '0;
        end else if (r_state == ST_DONE) begin
            r_acc  <= w_sum;
            r_conv <= r_conv + 1'b1;
        end
    end
`else
    assign w_final = 1'b1;
    assign w_res   = r_dac;
`endif

    // Resolve the current bit, then raise the next trial bit if one remains.
    always_comb begin
        w_dac_dec = r_dac;
        if (!w_cmp_s) w_dac_dec[r_ptr] = 1'b0;
        if (!w_last)  w_dac_dec[r_ptr - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (abort)          w_state_nxt = ST_IDLE;
                else if (w_settled) w_state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
                else             w_state_nxt = ST_SETTLE;
            end
            ST_DONE:   w_state_nxt = w_final ? ST_IDLE : ST_SETTLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= C_PTR_TOP;
            r_cnt    <= '0;
            r_dac    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_dac  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_dac  <= C_MSB;
                            r_ptr  <= C_PTR_TOP;
                            r_busy <= 1'b1;
                        end
                    end
                    ST_SETTLE: r_cnt <= w_settled ? '0 : r_cnt + 1'b1;
                    ST_DECIDE: begin
                        r_dac <= w_dac_dec;
                        if (!w_last) r_ptr <= r_ptr - 1'b1;
                    end
                    ST_DONE: begin
                        if (w_final) begin
                            r_result <= w_res;
                            r_done   <= 1'b1;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_dac    <= '0;
                        end else begin
                            r_dac <= C_MSB;
                            r_ptr <= C_PTR_TOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dac_code = r_dac;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign valid    = r_valid;

endmodule : sar_adc_ctrl
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sar_adc_ctrl : directed self-checking bench for sar_adc_ctrl
// Build with SAR_AVG_EN defined to exercise the averaging variant.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cmp_in;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       valid;

    logic [7:0] vin_code;
    logic [1:0] cmp_mode;   // 0: ideal, 1: stuck high, 2: stuck low

    int n_tests;
    int n_fail;

    sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cmp_in   (cmp_in),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .valid    (valid)
    );

    // Analog input modelled half an LSB above vin_code, so a code equal to vin keeps its bit.
    assign cmp_in = (cmp_mode == 2'd1) ? 1'b1 :
                    (cmp_mode == 2'd2) ? 1'b0 :
                    ({vin_code, 1'b1} > {dac_code, 1'b0});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

`ifndef SAR_AVG_EN
    task automatic conv(input logic [7:0] vin, input logic [7:0] exp, input string tag);
        int lat;
        int ndone;
        lat = -1;
        ndone = 0;
        vin_code = vin;
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        check({tag, "_lat"}, lat, 25);
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_result"}, result, exp);
        check({tag, "_valid"}, valid, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask
`endif

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        vin_code = 8'h00;
        cmp_mode = 2'd0;

        repeat (3) @(negedge clk);
        check("rst_dac", dac_code, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_valid", valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef SAR_AVG_EN
        begin
            int lat;
            int ndone;
            lat = -1;
            ndone = 0;
            vin_code = 8'd10;
            pulse_start();
            for (int k = 1; k <= 110; k++) begin
                @(negedge clk);
                if (k == 25) vin_code = 8'd11;
                if (k == 50) vin_code = 8'd12;
                if (k == 75) vin_code = 8'd13;
                if (done) begin
                    ndone++;
                    if (lat < 0) lat = k;
                end
            end
            check("avg_lat", lat, 100);
            check("avg_ndone", ndone, 1);
            check("avg_result", result, 8'd11);
            check("avg_valid", valid, 1);
        end
`else
        // vin = A5: trial code at each decision boundary, then the final code.
        begin
            logic [7:0] trace [8];
            int lat;
            trace = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
            lat = -1;
            vin_code = 8'hA5;
            pulse_start();
            check("a5_busy_start", busy, 1);
            check("a5_trial0", dac_code, trace[0]);
            for (int k = 1; k <= 26; k++) begin
                @(negedge clk);
                if ((k % 3 == 0) && (k <= 21)) check($sformatf("a5_trial%0d", k / 3), dac_code, trace[k / 3]);
                if (k == 24) check("a5_final_code", dac_code, 8'hA5);
                if (done && lat < 0) lat = k;
                if (k == 26) check("a5_done_width", done, 0);
            end
            check("a5_lat", lat, 25);
            check("a5_result", result, 8'hA5);
            check("a5_valid", valid, 1);
            check("a5_dac_idle", dac_code, 0);
        end

        cmp_mode = 2'd1;
        conv(8'h12, 8'hFF, "ones");
        cmp_mode = 2'd2;
        conv(8'hED, 8'h00, "zeros");
        cmp_mode = 2'd0;

        // Second start at cycle 10 must be ignored.
        begin
            int lat;
            int ndone;
            lat = -1;
            ndone = 0;
            vin_code = 8'h3C;
            pulse_start();
            for (int k = 1; k <= 45; k++) begin
                @(negedge clk);
                if (k == 10) start = 1'b1;
                if (k == 11) start = 1'b0;
                if (done) begin
                    ndone++;
                    if (lat < 0) lat = k;
                end
            end
            check("coll_lat", lat, 25);
            check("coll_ndone", ndone, 1);
            check("coll_result", result, 8'h3C);
            check("coll_busy_end", busy, 0);
        end

        // Abort at cycle 12 of an F0 conversion.
        begin
            int ndone;
            ndone = 0;
            vin_code = 8'hF0;
            pulse_start();
            repeat (12) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_dac", dac_code, 0);
            check("abort_done", done, 0);
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (done) ndone++;
            end
            check("abort_ndone", ndone, 0);
            check("abort_result", result, 8'h3C);
            check("abort_valid", valid, 1);
        end

        // Start and abort together in IDLE.
        vin_code = 8'h80;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_dac", dac_code, 0);
        repeat (5) @(negedge clk);
        check("sa_busy_later", busy, 0);
        check("sa_result", result, 8'h3C);

        // Asynchronous reset mid-conversion.
        vin_code = 8'h5A;
        pulse_start();
        repeat (15) @(negedge clk);
        check("mid_dac_nonzero", (dac_code != 8'h00), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dac", dac_code, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_valid", valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        conv(8'h5A, 8'h5A, "post_rst");

        // Start held high: back-to-back conversions.
        begin
            int lat1;
            int lat2;
            lat1 = -1;
            lat2 = -1;
            vin_code = 8'h33;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (done) begin
                    lat1 = k;
                    break;
                end
            end
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (done) begin
                    lat2 = k;
                    break;
                end
            end
            start = 1'b0;
            check("b2b_lat1", lat1, 25);
            check("b2b_lat2", lat2, 26);
            check("b2b_result", result, 8'h33);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sar_adc_ctrl
`default_nettype wire
